// File: rtl/poly_synth_core.sv
// ============================================================================
// Module   : poly_synth_core
// Brief    : Polyphonic tone generator with note allocation, per-voice
//            waveform/envelope and one saturated mixed sample per tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module poly_synth_core #(
    parameter int VOICES       = 4,
    parameter int PHASE_W      = 16,
    parameter int OUT_W        = 16,
    parameter int ENV_W        = 8,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_tick,
    input  logic               note_valid,
    output logic               note_ready,
    input  logic               note_on,
    input  logic [PHASE_W-1:0] note_freq,
    input  logic [1:0]         note_wave,
    input  logic [2:0]         vol_shift,
    output logic [OUT_W-1:0]   audio_out,
    output logic               audio_valid,
    output logic [VOICES-1:0]  voice_active
);

    localparam int c_IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int c_ACC_W  = OUT_W + 3;
    localparam int c_PROD_W = ENV_W + 18;
    localparam logic [ENV_W-1:0] c_ENV_MAX  = '1;
    localparam logic [ENV_W:0]   c_ATK_STEP = (ENV_W + 1)'(ATTACK_STEP);
    localparam logic [ENV_W-1:0] c_REL_STEP = ENV_W'(RELEASE_STEP);
    localparam logic signed [c_ACC_W-1:0] c_OUT_MAX = c_ACC_W'(2**(OUT_W - 1) - 1);
    localparam logic signed [c_ACC_W-1:0] c_OUT_MIN = ~c_OUT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } voice_state_t;

    voice_state_t               r_state [VOICES];
    logic [PHASE_W-1:0]         r_freq  [VOICES];
    logic [PHASE_W-1:0]         r_phase [VOICES];
    logic [1:0]                 r_wave  [VOICES];
    logic [ENV_W-1:0]           r_env   [VOICES];
    logic                       r_busy;
    logic [c_IDX_W-1:0]         r_idx;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic [OUT_W-1:0]           r_audio;
    logic                       r_valid;

    logic                       w_accept;
    logic                       w_idle_found;
    logic                       w_rel_found;
    logic [c_IDX_W-1:0]         w_idle_idx;
    logic [c_IDX_W-1:0]         w_rel_idx;
    logic                       w_alloc_ok;
    logic [c_IDX_W-1:0]         w_alloc_idx;
    voice_state_t               w_cur_state;
    logic [PHASE_W-1:0]         w_cur_phase;
    logic [PHASE_W-1:0]         w_cur_freq;
    logic [1:0]                 w_cur_wave;
    logic [ENV_W-1:0]           w_cur_env;
    logic [15:0]                w_p;
    logic signed [16:0]         w_wave;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [16:0]         w_vsample;
    logic signed [c_ACC_W-1:0]  w_acc_next;
    logic signed [c_ACC_W-1:0]  w_shifted;
    logic [OUT_W-1:0]           w_sat;
    logic [ENV_W:0]             w_env_up;

    assign w_accept = note_valid & ~r_busy;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_idle_found = 1'b0;
        w_idle_idx   = '0;
        w_rel_found  = 1'b0;
        w_rel_idx    = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (r_state[i] == ST_IDLE) begin
                w_idle_found = 1'b1;
                w_idle_idx   = c_IDX_W'(i);
            end
            if (r_state[i] == ST_RELEASE) begin
                w_rel_found = 1'b1;
                w_rel_idx   = c_IDX_W'(i);
            end
        end
    end

    assign w_alloc_ok  = w_idle_found | w_rel_found;
    assign w_alloc_idx = w_idle_found ? w_idle_idx : w_rel_idx;

    assign w_cur_state = r_state[r_idx];
    assign w_cur_phase = r_phase[r_idx];
    assign w_cur_freq  = r_freq[r_idx];
    assign w_cur_wave  = r_wave[r_idx];
    assign w_cur_env   = r_env[r_idx];

    if (PHASE_W >= 16) begin : g_p_top
        assign w_p = w_cur_phase[PHASE_W-1 -: 16];
    end else begin : g_p_ext
        assign w_p = {{(16 - PHASE_W){1'b0}}, w_cur_phase};
    end

    always_comb begin
        case (w_cur_wave)
            2'd0:    w_wave = w_p[15] ? -17'sd32767 : 17'sd32767;
            2'd1:    w_wave = $signed({1'b0, w_p}) - 17'sd32768;
            2'd2:    w_wave = w_p[15] ? 17'sd32767 - $signed({1'b0, w_p[14:0], 1'b0})
                                      : $signed({1'b0, w_p[14:0], 1'b0}) - 17'sd32768;
            default: w_wave = '0;
        endcase
        if (w_cur_state == ST_IDLE) begin
            w_wave = '0;
        end
    end

    assign w_prod     = c_PROD_W'(w_wave) * c_PROD_W'($signed({1'b0, w_cur_env}));
    assign w_vsample  = 17'(w_prod >>> ENV_W);
    assign w_acc_next = r_acc + c_ACC_W'(w_vsample);
    assign w_shifted  = w_acc_next >>> vol_shift;

    always_comb begin
        if (w_shifted > c_OUT_MAX) begin
            w_sat = c_OUT_MAX[OUT_W-1:0];
        end else if (w_shifted < c_OUT_MIN) begin
            w_sat = c_OUT_MIN[OUT_W-1:0];
        end else begin
            w_sat = w_shifted[OUT_W-1:0];
        end
    end

    assign w_env_up = {1'b0, w_cur_env} + c_ATK_STEP;

    // Events are only accepted while idle, so they never collide with pass updates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                r_state[i] <= ST_IDLE;
                r_freq[i]  <= '0;
                r_phase[i] <= '0;
                r_wave[i]  <= '0;
                r_env[i]   <= '0;
            end
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_audio <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                if (note_on) begin
                    if ((note_freq != '0) && w_alloc_ok) begin
                        r_state[w_alloc_idx] <= ST_ATTACK;
                        r_freq[w_alloc_idx]  <= note_freq;
                        r_wave[w_alloc_idx]  <= note_wave;
                        r_phase[w_alloc_idx] <= '0;
                        r_env[w_alloc_idx]   <= '0;
                    end
                end else begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (((r_state[i] == ST_ATTACK) || (r_state[i] == ST_SUSTAIN)) &&
                            (r_freq[i] == note_freq)) begin
                            r_state[i] <= ST_RELEASE;
                        end
                    end
                end
            end

            if (!r_busy) begin
                if (sample_tick) begin
                    r_busy <= 1'b1;
                    r_idx  <= '0;
                    r_acc  <= '0;
                end
            end else begin
                r_acc <= w_acc_next;
                if (w_cur_state != ST_IDLE) begin
                    r_phase[r_idx] <= w_cur_phase + w_cur_freq;
                    case (w_cur_state)
                        ST_ATTACK: begin
                            if (w_env_up >= {1'b0, c_ENV_MAX}) begin
                                r_env[r_idx]   <= c_ENV_MAX;
                                r_state[r_idx] <= ST_SUSTAIN;
                            end else begin
                                r_env[r_idx] <= w_env_up[ENV_W-1:0];
                            end
                        end
                        ST_RELEASE: begin
                            if (w_cur_env <= c_REL_STEP) begin
                                r_env[r_idx]   <= '0;
                                r_state[r_idx] <= ST_IDLE;
                            end else begin
                                r_env[r_idx] <= w_cur_env - c_REL_STEP;
                            end
                        end
                        default: ;
                    endcase
                end
                if (r_idx == c_IDX_W'(VOICES - 1)) begin
                    r_busy  <= 1'b0;
                    r_audio <= w_sat;
                    r_valid <= 1'b1;
                end else begin
                    r_idx <= r_idx + c_IDX_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_active
        assign voice_active[gi] = (r_state[gi] != ST_IDLE);
    end

    assign note_ready  = ~r_busy;
    assign audio_out   = r_audio;
    assign audio_valid = r_valid;

endmodule

`default_nettype wire
